// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART command-frame parser.
package uart_frame_pkg;

    // Parser states, in frame order.
    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        CMD     = 3'd1,
        LEN     = 3'd2,
        PAYLOAD = 3'd3,
        CSUM    = 3'd4
    } frame_state_t;

    // Abort causes reported on err_code.
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_LEN     = 2'd2;
    localparam logic [1:0] ERR_CSUM    = 2'd3;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_byte_strobe.sv
// Turns the UART receiver's level-type valid into a one-cycle byte strobe.
// The delay flop resets high so the receiver's idle-high level after reset
// is not mistaken for a freshly completed byte.
module uart_byte_strobe (
    input  logic clk,
    input  logic reset,
    input  logic rx_valid,
    output logic byte_stb
);

    logic rx_valid_d;

    // Delay flop for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_valid_d <= 1'b1;
        end else begin
            rx_valid_d <= rx_valid;
        end
    end

    assign byte_stb = rx_valid & ~rx_valid_d;

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles SYNC/CMD/LEN/payload/CHECKSUM frames from the UART byte stream,
// commits verified frames to a readable buffer and reports aborted frames.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   HUNT    | idle, discarding bytes until SYNC_BYTE arrives
//   CMD     | waiting for the command byte
//   LEN     | waiting for the payload length (0..MAX_LEN)
//   PAYLOAD | collecting payload bytes into the working buffer
//   CSUM    | waiting for the XOR checksum; commit or abort
//
// The committed buffer is only written on a successful checksum, so game
// logic can keep reading the previous frame while the next one arrives.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int         MAX_LEN        = 8,
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       frame_valid,
    output logic [7:0] frame_cmd,
    output logic [3:0] frame_len,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       err_pulse,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int                 TIMER_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]         MAX_LEN_B  = 8'(MAX_LEN);

    frame_state_t       state;
    frame_state_t       state_n;
    logic               byte_stb;
    logic [7:0]         acc;
    logic [7:0]         acc_n;
    logic [7:0]         cmd_work;
    logic [7:0]         cmd_n;
    logic [3:0]         len_work;
    logic [3:0]         len_n;
    logic [3:0]         idx;
    logic [3:0]         idx_n;
    logic [TIMER_W-1:0] timer;
    logic               timer_hit;
    logic               buf_we;
    logic               commit;
    logic               abort;
    logic [1:0]         abort_code;
    logic [7:0]         work_buf   [MAX_LEN];
    logic [7:0]         commit_buf [MAX_LEN];

    uart_byte_strobe u_byte_strobe (
        .clk      (clk),
        .reset    (reset),
        .rx_valid (rx_valid),
        .byte_stb (byte_stb)
    );

    // A byte arriving in the same cycle as the limit still counts, so the
    // timeout is only taken when no strobe is present.
    assign timer_hit = (state != HUNT) && (timer == TIMER_LAST);
    assign busy      = (state != HUNT);

    // State and working-field registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= HUNT;
            acc      <= 8'h00;
            cmd_work <= 8'h00;
            len_work <= 4'h0;
            idx      <= 4'h0;
        end else begin
            state    <= state_n;
            acc      <= acc_n;
            cmd_work <= cmd_n;
            len_work <= len_n;
            idx      <= idx_n;
        end
    end

    // Next-state, checksum accumulation and commit/abort decisions.
    always_comb begin
        state_n    = state;
        acc_n      = acc;
        cmd_n      = cmd_work;
        len_n      = len_work;
        idx_n      = idx;
        buf_we     = 1'b0;
        commit     = 1'b0;
        abort      = 1'b0;
        abort_code = ERR_NONE;

        case (state)
            HUNT: begin
                if (byte_stb && (rx_data == SYNC_BYTE)) begin
                    state_n = CMD;
                    acc_n   = 8'h00;
                end
            end
            CMD: begin
                if (byte_stb) begin
                    cmd_n   = rx_data;
                    acc_n   = acc ^ rx_data;
                    state_n = LEN;
                end
            end
            LEN: begin
                if (byte_stb) begin
                    if (rx_data > MAX_LEN_B) begin
                        abort      = 1'b1;
                        abort_code = ERR_LEN;
                        state_n    = HUNT;
                    end else begin
                        len_n   = rx_data[3:0];
                        acc_n   = acc ^ rx_data;
                        idx_n   = 4'h0;
                        state_n = (rx_data == 8'h00) ? CSUM : PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (byte_stb) begin
                    buf_we = 1'b1;
                    acc_n  = acc ^ rx_data;
                    idx_n  = idx + 4'd1;
                    if ((idx + 4'd1) == len_work) begin
                        state_n = CSUM;
                    end
                end
            end
            CSUM: begin
                if (byte_stb) begin
                    if (rx_data == acc) begin
                        commit = 1'b1;
                    end else begin
                        abort      = 1'b1;
                        abort_code = ERR_CSUM;
                    end
                    state_n = HUNT;
                end
            end
            default: begin
                state_n = HUNT;
            end
        endcase

        if (timer_hit && !byte_stb) begin
            state_n    = HUNT;
            abort      = 1'b1;
            abort_code = ERR_TIMEOUT;
        end
    end

    // Inter-byte timer: runs inside a frame, restarts on every byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (byte_stb || (state == HUNT) || abort) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Working buffer fills during PAYLOAD; committed copy only on a good checksum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                work_buf[i]   <= 8'h00;
                commit_buf[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if (buf_we && (idx == 4'(i))) begin
                    work_buf[i] <= rx_data;
                end
                if (commit) begin
                    commit_buf[i] <= work_buf[i];
                end
            end
        end
    end

    // Registered frame/error outputs, one cycle after the deciding byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_valid <= 1'b0;
            err_pulse   <= 1'b0;
            frame_cmd   <= 8'h00;
            frame_len   <= 4'h0;
            err_code    <= ERR_NONE;
        end else begin
            frame_valid <= commit;
            err_pulse   <= abort;
            if (commit) begin
                frame_cmd <= cmd_work;
                frame_len <= len_work;
            end
            if (abort) begin
                err_code <= abort_code;
            end
        end
    end

    // Payload read port; entries past the committed length read as zero.
    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((rd_addr == 4'(i)) && (rd_addr < frame_len)) begin
                rd_data = commit_buf[i];
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: directed frames from the test
// plan followed by randomized frames, all checked against a byte-level
// queue model of the framing rules.
`timescale 1ns/1ps
module tb_uart_frame_parser;

    localparam int         MAX_LEN = 8;
    localparam int         TMO     = 1000;
    localparam logic [7:0] SYNC    = 8'hA5;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       rx_valid = 1'b1;
    logic [7:0] rx_data  = 8'h00;
    logic [3:0] rd_addr  = 4'h0;
    logic       frame_valid;
    logic [7:0] frame_cmd;
    logic [3:0] frame_len;
    logic [7:0] rd_data;
    logic       err_pulse;
    logic [1:0] err_code;
    logic       busy;

    always #5 clk = ~clk;

    uart_frame_parser #(
        .MAX_LEN        (MAX_LEN),
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .frame_valid (frame_valid),
        .frame_cmd   (frame_cmd),
        .frame_len   (frame_len),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .err_pulse   (err_pulse),
        .err_code    (err_code),
        .busy        (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse monitor.
    int fv_seen   = 0;
    int ep_seen   = 0;
    int both_seen = 0;
    always @(negedge clk) begin
        if (frame_valid === 1'b1) fv_seen++;
        if (err_pulse === 1'b1) ep_seen++;
        if ((frame_valid === 1'b1) && (err_pulse === 1'b1)) both_seen++;
    end

    // Reference model: bytes of the frame in progress (starting with SYNC),
    // plus the committed frame and the last error code.
    logic [7:0] cur [$];
    logic [7:0] m_cmd;
    logic [3:0] m_len;
    logic [7:0] m_buf [16];
    logic [1:0] m_err;
    logic [7:0] tx_q [$];

    function automatic void model_reset();
        cur.delete();
        m_cmd = 8'h00;
        m_len = 4'h0;
        m_err = 2'd0;
        for (int i = 0; i < 16; i++) m_buf[i] = 8'h00;
    endfunction

    // ev: 0 nothing, 1 frame committed, 2 frame aborted
    function automatic void model_byte(input logic [7:0] b, output int ev);
        logic [7:0] x;
        ev = 0;
        if (cur.size() == 0) begin
            if (b == SYNC) cur.push_back(b);
            return;
        end
        cur.push_back(b);
        if ((cur.size() == 3) && (int'(b) > MAX_LEN)) begin
            ev    = 2;
            m_err = 2'd2;
            cur.delete();
            return;
        end
        if ((cur.size() >= 3) && (cur.size() == int'(cur[2]) + 4)) begin
            x = 8'h00;
            for (int i = 1; i < cur.size() - 1; i++) x = x ^ cur[i];
            if (x == b) begin
                ev    = 1;
                m_cmd = cur[1];
                m_len = cur[2][3:0];
                for (int i = 0; i < int'(cur[2]); i++) m_buf[i] = cur[3 + i];
            end else begin
                ev    = 2;
                m_err = 2'd3;
            end
            cur.delete();
        end
    endfunction

    task automatic check_buf();
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            #1;
            check("rd_data", rd_data, (a < int'(m_len)) ? m_buf[a] : 8'h00);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int ev;
        rx_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        model_byte(b, ev);
        @(negedge clk);
        check("frame_valid", frame_valid, ev == 1);
        check("err_pulse", err_pulse, ev == 2);
        check("err_code", err_code, m_err);
        check("frame_cmd", frame_cmd, m_cmd);
        check("frame_len", frame_len, m_len);
        check("busy", busy, cur.size() != 0);
        @(negedge clk);
        check("pulse_width", {frame_valid, err_pulse}, 2'b00);
        check_buf();
    endtask

    task automatic send_q();
        while (tx_q.size() != 0) send_byte(tx_q.pop_front(), $urandom_range(1, 4));
    endtask

    int ev_tmp;
    int j;
    int f0;
    int e0;
    int kind;
    int len;
    logic [7:0] cks;
    logic [7:0] bv;

    initial begin
        model_reset();

        // Reset with the receiver idling high.
        reset    = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_outs", {frame_valid, err_pulse, frame_cmd, frame_len, err_code}, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("post_rst_pulses", fv_seen + ep_seen, 0);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_outs", {frame_valid, err_pulse, frame_cmd, frame_len, err_code}, 0);
        check_buf();

        // Good frame with leading garbage.
        f0 = fv_seen;
        tx_q = '{8'h00, 8'hFF, 8'hA5, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h13};
        send_q();
        check("good_count", fv_seen - f0, 1);
        check("good_cmd", frame_cmd, 8'h10);
        check("good_len", frame_len, 4'd3);
        rd_addr = 4'd0; #1 check("good_rd0", rd_data, 8'h01);
        rd_addr = 4'd1; #1 check("good_rd1", rd_data, 8'h02);
        rd_addr = 4'd2; #1 check("good_rd2", rd_data, 8'h03);
        rd_addr = 4'd3; #1 check("good_rd3", rd_data, 8'h00);

        // Bad checksum keeps the previous frame.
        f0 = fv_seen;
        e0 = ep_seen;
        tx_q = '{8'hA5, 8'h10, 8'h01, 8'h55, 8'h00};
        send_q();
        check("csum_err_count", ep_seen - e0, 1);
        check("csum_no_frame", fv_seen - f0, 0);
        check("csum_code", err_code, 2'd3);
        check("csum_keep_len", frame_len, 4'd3);
        rd_addr = 4'd1; #1 check("csum_keep_rd1", rd_data, 8'h02);

        // Zero-length frame.
        tx_q = '{8'hA5, 8'h22, 8'h00, 8'h22};
        send_q();
        check("zero_cmd", frame_cmd, 8'h22);
        check("zero_len", frame_len, 4'd0);

        // Length error, trailing bytes ignored, then a good frame.
        tx_q = '{8'hA5, 8'h10, 8'h09, 8'h01, 8'h02};
        send_q();
        check("len_code", err_code, 2'd2);
        check("len_busy", busy, 1'b0);
        tx_q = '{8'hA5, 8'h30, 8'h02, 8'hA5, 8'hA5, 8'h32};
        send_q();
        check("resync_free_cmd", frame_cmd, 8'h30);
        check("resync_free_len", frame_len, 4'd2);

        // Timeout: error exactly TMO cycles after the last strobe.
        send_byte(SYNC, 1);
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        rx_data  = 8'h10;
        rx_valid = 1'b1;
        @(posedge clk);
        model_byte(8'h10, ev_tmp);
        j = 0;
        while (j < TMO + 100) begin
            @(negedge clk);
            if (err_pulse === 1'b1) break;
            @(posedge clk);
            j++;
        end
        cur.delete();
        m_err = 2'd1;
        check("tmo_latency", j, TMO);
        check("tmo_code", err_code, 2'd1);
        check("tmo_busy", busy, 1'b0);
        check("tmo_no_frame", frame_valid, 1'b0);
        @(negedge clk);
        check("tmo_pulse_width", err_pulse, 1'b0);

        // A byte in the last allowed cycle beats the timeout.
        send_byte(SYNC, 1);
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        rx_data  = 8'h10;
        rx_valid = 1'b1;
        @(posedge clk);
        model_byte(8'h10, ev_tmp);
        #1 rx_valid = 1'b0;
        e0 = ep_seen;
        repeat (TMO - 1) @(posedge clk);
        #1;
        rx_data  = 8'h02;
        rx_valid = 1'b1;
        @(posedge clk);
        model_byte(8'h02, ev_tmp);
        repeat (3) @(negedge clk);
        check("tmo_edge_no_err", ep_seen - e0, 0);
        check("tmo_edge_busy", busy, 1'b1);
        tx_q = '{8'h11, 8'h22, 8'h21};
        send_q();
        check("tmo_edge_cmd", frame_cmd, 8'h10);
        check("tmo_edge_len", frame_len, 4'd2);

        // Reset in the middle of a payload.
        tx_q = '{8'hA5, 8'h40, 8'h03, 8'h07};
        send_q();
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_outs", {frame_valid, err_pulse, frame_cmd, frame_len, err_code}, 0);
        model_reset();
        f0 = fv_seen;
        e0 = ep_seen;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("midrst_pulses", (fv_seen - f0) + (ep_seen - e0), 0);
        check_buf();

        // Randomized frames.
        for (int f = 0; f < 60; f++) begin
            kind = $urandom_range(0, 3);
            tx_q.delete();
            if (kind <= 1) begin
                len = $urandom_range(0, MAX_LEN);
                bv  = 8'($urandom);
                tx_q.push_back(SYNC);
                tx_q.push_back(bv);
                tx_q.push_back(8'(len));
                cks = bv ^ 8'(len);
                for (int k = 0; k < len; k++) begin
                    bv = ($urandom_range(0, 5) == 0) ? SYNC : 8'($urandom);
                    tx_q.push_back(bv);
                    cks = cks ^ bv;
                end
                if (kind == 1) cks = cks ^ 8'($urandom_range(1, 255));
                tx_q.push_back(cks);
            end else if (kind == 2) begin
                tx_q.push_back(SYNC);
                tx_q.push_back(8'($urandom));
                tx_q.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
                tx_q.push_back(8'($urandom));
            end else begin
                for (int k = 0; k < 3; k++) tx_q.push_back(8'($urandom));
            end
            send_q();
        end

        check("never_both_pulses", both_seen, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
